// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared TMDS symbol width, control tokens and popcount helper
package hdmi_pkg;
    localparam int TMDS_SYM_W = 10;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'b0, v[i]};
    endfunction
endpackage

// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if: pixel/control inputs and encoded symbol of one TMDS channel
interface tmds_encoder_if;
    logic blank;
    logic [7:0] data_in;
    logic c0;
    logic c1;
    logic [hdmi_pkg::TMDS_SYM_W-1:0] tmds_out;
    modport master (output blank, data_in, c0, c1, input tmds_out);
    modport slave (input blank, data_in, c0, c1, output tmds_out);
endinterface

// File: rtl/tmds_encoder.sv
// tmds_encoder: two-stage DVI 8b/10b TMDS channel encoder
module tmds_encoder
    import hdmi_pkg::*;
#(
    parameter logic BLANK_ACTIVE = 1'b1
) (
    input logic clk,
    input logic rst,
    tmds_encoder_if.slave bus
);
    logic [3:0] n1_in;
    logic use_xnor;
    logic [8:0] qm_next;
    logic [8:0] qm;
    logic de;
    logic c0;
    logic c1;
    logic [3:0] n1;
    logic signed [4:0] diff;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_next;
    logic [TMDS_SYM_W-1:0] sym;
    logic [TMDS_SYM_W-1:0] sym_next;
    logic [TMDS_SYM_W-1:0] token;

    // transition-minimise: each q_m bit is a prefix parity, flipped on odd bits when chaining with XNOR
    always_comb begin
        n1_in = popcount8(bus.data_in);
        use_xnor = (n1_in > 4'd4) || (n1_in == 4'd4 && !bus.data_in[0]);
        for (int i = 0; i < 8; i++)
            qm_next[i] = ^(bus.data_in & 8'((9'd2 << i) - 9'd1)) ^ (use_xnor & i[0]);
        qm_next[8] = !use_xnor;
    end

    // stage 1 register: q_m plus de/control bits aligned to it
    always_ff @(posedge clk) begin
        if (rst) begin
            qm <= '0;
            de <= 1'b0;
            c0 <= 1'b0;
            c1 <= 1'b0;
        end else begin
            qm <= qm_next;
            de <= (bus.blank != BLANK_ACTIVE);
            c0 <= bus.c0;
            c1 <= bus.c1;
        end
    end

    // DC balancing: pick inversion from running disparity, or emit a control token while blanked
    always_comb begin
        n1 = popcount8(qm[7:0]);
        diff = $signed({n1, 1'b0} - 5'd8);
        token = c1 ? (c0 ? CTRL_TOKEN_11 : CTRL_TOKEN_10) : (c0 ? CTRL_TOKEN_01 : CTRL_TOKEN_00);
        sym_next = token;
        cnt_next = '0;
        if (!de) begin
            sym_next = token;
            cnt_next = '0;
        end else if (cnt == 5'sd0 || diff == 5'sd0) begin
            sym_next = {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_next = cnt + (qm[8] ? diff : -diff);
        end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
            sym_next = {1'b1, qm[8], ~qm[7:0]};
            cnt_next = cnt + $signed({3'b0, qm[8], 1'b0}) - diff;
        end else begin
            sym_next = {1'b0, qm[8], qm[7:0]};
            cnt_next = cnt + diff - $signed({3'b0, !qm[8], 1'b0});
        end
    end

    // stage 2 register: output symbol and running disparity
    always_ff @(posedge clk) begin
        if (rst) begin
            sym <= CTRL_TOKEN_00;
            cnt <= '0;
        end else begin
            sym <= sym_next;
            cnt <= cnt_next;
        end
    end

    assign bus.tmds_out = sym;
endmodule
